// File: rtl/strobe_cdc_hs_if.sv
// Source/destination handshake bundle for the strobe CDC block.
interface strobe_cdc_hs_if #(
  parameter int unsigned DW = 8
);
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          src_done;
  logic          src_drop;
  logic          dst_valid;
  logic [DW-1:0] dst_data;

  // Requester side: offers words, observes handshake status and delivery.
  modport master (
    output src_valid,
    output src_data,
    input  src_ready,
    input  src_done,
    input  src_drop,
    input  dst_valid,
    input  dst_data
  );

  // Crossing block side.
  modport slave (
    input  src_valid,
    input  src_data,
    output src_ready,
    output src_done,
    output src_drop,
    output dst_valid,
    output dst_data
  );
endinterface

// File: rtl/strobe_cdc_hs.sv
// Four-phase req/ack clock-domain crossing for a single data word.
// The source holding register is stable while req is high, so the
// destination may sample it directly once the synchronized req rises.
module strobe_cdc_hs #(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_src,
  input  logic              clk_dst,
  input  logic              rst_n,
  strobe_cdc_hs_if.slave    hs
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_ACKWAIT = 2'd2
  } state_e;

  // Source domain
  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   drop_q, drop_d;
  logic                   load_d;
  logic [DW-1:0]          hold_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;

  // Destination domain
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   req_s;
  logic                   ack_q;
  logic                   req_rise;
  logic                   dvalid_q;
  logic [DW-1:0]          ddata_q;

  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign req_s    = req_sync_q[SYNC_STAGES-1];
  assign req_rise = req_s && !ack_q;

  // Bring the destination ack back into the source domain.
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_q};
    end
  end

  // Source FSM next state and registered-output next values.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    done_d  = 1'b0;
    drop_d  = hs.src_valid && !ready_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs.src_valid && ready_q) begin
          state_d = S_REQ;
          load_d  = 1'b1;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          state_d = S_ACKWAIT;
        end
      end
      S_ACKWAIT: begin
        if (!ack_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_d   = (state_d == S_REQ);
    // Ready reopens only the cycle after done so no accept overlaps it.
    ready_d = (state_d == S_IDLE) && (state_q != S_ACKWAIT);
  end

  // Source state, req launch flop, status outputs and holding register.
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      if (load_d) begin
        hold_q <= hs.src_data;
      end
    end
  end

  // Synchronize req, edge-detect it (the delayed copy doubles as ack)
  // and capture the held word on the rising edge.
  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= '0;
      ack_q      <= 1'b0;
      dvalid_q   <= 1'b0;
      ddata_q    <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
      ack_q      <= req_s;
      dvalid_q   <= req_rise;
      if (req_rise) begin
        ddata_q <= hold_q;
      end
    end
  end

  assign hs.src_ready = ready_q;
  assign hs.src_done  = done_q;
  assign hs.src_drop  = drop_q;
  assign hs.dst_valid = dvalid_q;
  assign hs.dst_data  = ddata_q;

endmodule

// File: tb/tb_strobe_cdc_hs.sv
// Directed and randomized bench for strobe_cdc_hs with a word scoreboard.
module tb_strobe_cdc_hs;
  localparam int unsigned DW    = 8;
  localparam int unsigned NRAND = 200;

  logic clk_src = 1'b0;
  logic clk_dst = 1'b0;
  logic rst_n   = 1'b1;

  int src_half = 5;
  int dst_half = 14;
  int dst_skew = 0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];
  int            acc_cnt   = 0;
  int            done_cnt  = 0;
  int            dv_cnt    = 0;
  int            drop_cnt  = 0;
  int            dst_edges = 0;
  int            acc_edge  = 0;
  int            dv_edge   = 0;
  logic [DW-1:0] last_dst  = '0;
  time           last_dv_time;
  bit            dv_prev   = 1'b0;
  bit            done_prev = 1'b0;

  strobe_cdc_hs_if #(.DW(DW)) hs ();

  strobe_cdc_hs #(.DW(DW), .SYNC_STAGES(2)) dut (
    .clk_src (clk_src),
    .clk_dst (clk_dst),
    .rst_n   (rst_n),
    .hs      (hs)
  );

  initial forever #(src_half) clk_src = ~clk_src;

  initial forever begin
    if (dst_skew != 0) begin
      #(dst_skew);
      dst_skew = 0;
    end
    #(dst_half) clk_dst = ~clk_dst;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_dst) dst_edges++;

  // Destination monitor: pulse width, scoreboard, data hold.
  always @(negedge clk_dst) begin
    if (rst_n) begin
      check("dv_single", 64'(hs.dst_valid && dv_prev), 64'd0);
      if (hs.dst_valid) begin
        dv_cnt++;
        dv_edge      = dst_edges;
        last_dv_time = $time;
        if (exp_q.size() == 0) begin
          check("dst_unexpected", 64'(hs.dst_valid), 64'd0);
        end else begin
          check("dst_data", 64'(hs.dst_data), 64'(exp_q.pop_front()));
        end
        last_dst = hs.dst_data;
      end else begin
        check("dst_hold", 64'(hs.dst_data), 64'(last_dst));
      end
      dv_prev = hs.dst_valid;
    end else begin
      dv_prev = 1'b0;
    end
  end

  // Source monitor: done pulse width, ready/req exclusion, event counts.
  always @(negedge clk_src) begin
    if (rst_n) begin
      check("done_single", 64'(hs.src_done && done_prev), 64'd0);
      check("ready_vs_req", 64'(hs.src_ready && dut.req_q), 64'd0);
      if (hs.src_done) done_cnt++;
      if (hs.src_drop) drop_cnt++;
      done_prev = hs.src_done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 64'(hs.src_ready), 64'd0);
    check({tag, "_done"},  64'(hs.src_done),  64'd0);
    check({tag, "_drop"},  64'(hs.src_drop),  64'd0);
    check({tag, "_dv"},    64'(hs.dst_valid), 64'd0);
    check({tag, "_ddata"}, 64'(hs.dst_data),  64'd0);
  endtask

  // Asserts reset immediately, retimes clocks, releases on a clk_src negedge.
  task automatic do_reset(input string tag, input int s_half, input int d_half, input int skew);
    rst_n = 1'b0;
    #1;
    check_outputs_zero(tag);
    exp_q.delete();
    acc_cnt  = 0;
    done_cnt = 0;
    dv_cnt   = 0;
    drop_cnt = 0;
    last_dst = '0;
    hs.src_valid = 1'b0;
    hs.src_data  = '0;
    src_half = s_half;
    dst_half = d_half;
    dst_skew = skew;
    repeat (4) @(posedge clk_dst);
    repeat (4) @(posedge clk_src);
    @(negedge clk_src);
    rst_n = 1'b1;
    check({tag, "_ready_at_release"}, 64'(hs.src_ready), 64'd0);
    @(posedge clk_src);
    #1;
    check({tag, "_ready_after_release"}, 64'(hs.src_ready), 64'd1);
    @(negedge clk_src);
  endtask

  // Entered and left on a clk_src negedge; leaves src_valid high.
  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    hs.src_valid = 1'b1;
    hs.src_data  = d;
    while (!hs.src_ready && n < 4000) begin
      @(negedge clk_src);
      n++;
    end
    if (!hs.src_ready) begin
      check("send_timeout", 64'(hs.src_ready), 64'd1);
      hs.src_valid = 1'b0;
      return;
    end
    @(posedge clk_src);
    exp_q.push_back(d);
    acc_cnt++;
    acc_edge = dst_edges;
    @(negedge clk_src);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && done_cnt == acc_cnt && hs.src_ready) && n < 6000) begin
      @(negedge clk_src);
      n++;
    end
    check({tag, "_drain"}, 64'(n < 6000), 64'd1);
  endtask

  initial begin
    int n;
    int d0, v0, c0;
    hs.src_valid = 1'b0;
    hs.src_data  = '0;
    #1;

    // Even dst skew keeps dst edges off the odd-time src edges.
    do_reset("rst0", 5, 14, 2);

    // Single word 0xA5: latency, delivery, then done, then ready.
    send(8'hA5);
    hs.src_valid = 1'b0;
    n = 0;
    while (!hs.src_done && n < 2000) begin
      @(negedge clk_src);
      n++;
    end
    check("t1_done_seen", 64'(hs.src_done), 64'd1);
    check("t1_ready_at_done", 64'(hs.src_ready), 64'd0);
    check("t1_dv_cnt", 64'(dv_cnt), 64'd1);
    check("t1_dst_data", 64'(hs.dst_data), 64'hA5);
    check("t1_dv_before_done", 64'(last_dv_time < $time), 64'd1);
    check("t1_latency", 64'(dv_edge - acc_edge), 64'd3);
    @(negedge clk_src);
    check("t1_ready_after_done", 64'(hs.src_ready), 64'd1);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);

    // Back-to-back 0x01..0x10 with src_valid held.
    v0 = dv_cnt;
    c0 = done_cnt;
    for (int i = 1; i <= 16; i++) send(DW'(i));
    hs.src_valid = 1'b0;
    wait_drain("t2");
    check("t2_dv_cnt", 64'(dv_cnt - v0), 64'd16);
    check("t2_done_cnt", 64'(done_cnt - c0), 64'd16);
    check("t2_last", 64'(last_dst), 64'h10);

    // Drop: 0x33 offered one cycle after 0x22 is accepted.
    v0 = dv_cnt;
    d0 = drop_cnt;
    send(8'h22);
    hs.src_data = 8'h33;
    @(negedge clk_src);
    hs.src_valid = 1'b0;
    wait_drain("t3");
    check("t3_drop_cnt", 64'(drop_cnt - d0), 64'd1);
    check("t3_dv_cnt", 64'(dv_cnt - v0), 64'd1);
    check("t3_last", 64'(last_dst), 64'h22);

    // Reset mid-handshake with 0x7E in flight: abort, nothing delivered.
    send(8'h7E);
    hs.src_valid = 1'b0;
    @(negedge clk_src);
    check("t4_in_req", 64'(dut.req_q), 64'd1);
    #2;
    do_reset("t4", 5, 14, 0);
    repeat (20) @(negedge clk_dst);
    check("t4_no_dv", 64'(dv_cnt), 64'd0);
    check("t4_no_done", 64'(done_cnt), 64'd0);
    check("t4_ready", 64'(hs.src_ready), 64'd1);

    // Random words at 1:1, 10:1 and 1:10 with random dst phase.
    for (int r = 0; r < 3; r++) begin
      int sh, dh;
      case (r)
        0:       begin sh = 5;  dh = 5;  end
        1:       begin sh = 5;  dh = 50; end
        default: begin sh = 50; dh = 5;  end
      endcase
      do_reset("rrst", sh, dh, int'($urandom_range(1, 40)));
      for (int w = 0; w < int'(NRAND); w++) begin
        send(DW'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          hs.src_valid = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk_src);
        end
      end
      hs.src_valid = 1'b0;
      wait_drain("rand");
      check("rand_dv_cnt", 64'(dv_cnt), 64'(NRAND));
      check("rand_done_cnt", 64'(done_cnt), 64'(NRAND));
      check("rand_sb_empty", 64'(exp_q.size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
